// File: rtl/waveform_loader.sv
// Byte-stream loader: parses SYNC/MODE/COUNT/data/CSUM frames into the 512x32 waveform RAM.
// Latency: RAM write strobe one cycle after the 4th byte of each phase word; done one cycle after COMMIT.
// Backpressure: in_ready drops while hold is high, during COMMIT and while reset is asserted.
module waveform_loader #(
    parameter logic [7:0] SYNC_BYTE  = 8'hA5,
    parameter logic [6:0] DEF_COUNT0 = 7'd98,
    parameter logic [6:0] DEF_COUNT1 = 7'd22,
    parameter logic [6:0] DEF_COUNT2 = 7'd52,
    parameter logic [6:0] DEF_COUNT3 = 7'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        hold,
    output logic        wr_en,
    output logic [8:0]  wr_addr,
    output logic [31:0] wr_data,
    input  logic [1:0]  cnt_sel,
    output logic [6:0]  cnt_out,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        IDLE, HDR_MODE, HDR_COUNT, DATA, CSUM, COMMIT
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  mode;
    logic [6:0]  n;
    logic [6:0]  phase;
    logic [1:0]  byte_idx;
    logic [23:0] word;
    logic [7:0]  sum;
    logic [6:0]  count [4];

    logic xfer;
    logic last_word;
    logic mode_bad;
    logic count_bad;

    assign xfer      = in_valid && in_ready;
    assign last_word = (phase + 7'd1) == n;
    assign mode_bad  = in_data[5:0] != 6'd0;
    assign count_bad = (in_data == 8'd0) || in_data[7];
    assign cnt_out   = count[cnt_sel];

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode; every move except COMMIT->IDLE needs an accepted byte
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (xfer && in_data == SYNC_BYTE) state_nxt = HDR_MODE;
            HDR_MODE:  if (xfer) state_nxt = mode_bad ? IDLE : HDR_COUNT;
            HDR_COUNT: if (xfer) state_nxt = count_bad ? IDLE : DATA;
            DATA:      if (xfer && byte_idx == 2'd3 && last_word) state_nxt = CSUM;
            CSUM:      if (xfer) state_nxt = (in_data == sum) ? COMMIT : IDLE;
            COMMIT:    state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Handshake and status outputs
    always_comb begin
        in_ready = !reset && !hold && (state != COMMIT);
        busy     = state != IDLE;
    end

    // Datapath: header latches, word assembly, running sum, RAM write and count commit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode     <= 2'd0;
            n        <= 7'd0;
            phase    <= 7'd0;
            byte_idx <= 2'd0;
            word     <= 24'd0;
            sum      <= 8'd0;
            wr_en    <= 1'b0;
            wr_addr  <= 9'd0;
            wr_data  <= 32'd0;
            done     <= 1'b0;
            error    <= 1'b0;
            count[0] <= DEF_COUNT0;
            count[1] <= DEF_COUNT1;
            count[2] <= DEF_COUNT2;
            count[3] <= DEF_COUNT3;
        end else begin
            wr_en <= 1'b0;
            done  <= (state == COMMIT);
            case (state)
                IDLE: begin
                    if (xfer && in_data == SYNC_BYTE) begin
                        error <= 1'b0;
                        sum   <= 8'd0;
                    end
                end
                HDR_MODE: begin
                    if (xfer) begin
                        mode <= in_data[7:6];
                        sum  <= sum + in_data;
                        if (mode_bad) error <= 1'b1;
                    end
                end
                HDR_COUNT: begin
                    if (xfer) begin
                        sum <= sum + in_data;
                        if (count_bad) begin
                            error <= 1'b1;
                        end else begin
                            n        <= in_data[6:0];
                            phase    <= 7'd0;
                            byte_idx <= 2'd0;
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
                        sum      <= sum + in_data;
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: word[7:0]   <= in_data;
                            2'd1: word[15:8]  <= in_data;
                            2'd2: word[23:16] <= in_data;
                            default: begin
                                // Top byte goes straight to the RAM bus
                                wr_en   <= 1'b1;
                                wr_addr <= {mode, phase};
                                wr_data <= {in_data, word};
                                phase   <= phase + 7'd1;
                            end
                        endcase
                    end
                end
                CSUM: begin
                    if (xfer && in_data != sum) error <= 1'b1;
                end
                COMMIT: begin
                    count[mode] <= n;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/waveform_loader.md
Name: waveform_loader

Overview:
- Writer side of the waveform lookup table: receives a byte-stream waveform image from the host link (SPI/UART bridge).
- Assembles 32-bit phase words and writes them into the 512x32 waveform RAM at (mode<<7)+phase.
- Holds the per-mode phase-count registers that the lookup block uses to bound a refresh.
- Sits between the host byte interface and the waveform RAM write port; the refresh engine uses `hold` to stall it.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker
- DEF_COUNT0, 98, reset phase count for mode 0 (INIT)
- DEF_COUNT1, 22, reset phase count for mode 1 (DU)
- DEF_COUNT2, 52, reset phase count for mode 2 (GC4)
- DEF_COUNT3, 0, reset phase count for mode 3 (unused)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- in_data  in  8  host byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader accepts byte; a transfer occurs when in_valid&&in_ready
- hold  in  1  refresh in progress, blocks acceptance
- wr_en  out  1  RAM write strobe
- wr_addr  out  9  RAM word address
- wr_data  out  32  RAM word
- cnt_sel  in  2  mode whose phase count is read
- cnt_out  out  7  phase count of cnt_sel (combinational mux of count registers)
- busy  out  1  frame in progress (state != IDLE)
- done  out  1  one-cycle pulse: frame committed
- error  out  1  sticky error flag

Behaviour:
- Reset values (async):
  - state=IDLE, in_ready=0 while reset is asserted, wr_en=0, wr_addr=0, wr_data=0, done=0, error=0.
  - count regs = DEF_COUNT0..3.
- in_ready = !hold && state!=COMMIT. Bytes are consumed only on a transfer.
- Frame format: SYNC, MODE, COUNT, N×4 data bytes, CSUM.
  - MODE: bits[7:6]=mode, bits[5:0] must be 0.
  - COUNT: N, legal range 1..127.
  - Data: each phase word is 4 bytes, LSB first.
  - CSUM: 8-bit modulo-256 sum of MODE, COUNT and all data bytes.
- States:
  - IDLE: non-SYNC bytes discarded. SYNC -> HDR_MODE, clears error and the running sum.
  - HDR_MODE: latch mode, add byte to the sum.
    - bits[5:0]!=0 -> error=1 -> IDLE.
    - else -> HDR_COUNT.
  - HDR_COUNT: N==0 or N>127 -> error=1 -> IDLE. Else latch N, phase=0, byte_idx=0 -> DATA.
  - DATA: shift byte into word[8*byte_idx +: 8], add to the sum, byte_idx++.
    - On the 4th byte (byte_idx==3), the next cycle gives wr_en=1, wr_addr={mode,phase[6:0]}, wr_data=assembled word; phase++, byte_idx=0.
    - After word N-1 -> CSUM.
  - CSUM: byte==sum -> COMMIT. Mismatch -> error=1 -> IDLE; count register is not updated.
  - COMMIT (1 cycle, in_ready=0): count[mode]<=N, done=1 -> IDLE.
- Write latency: wr_en is asserted exactly 1 cycle after the 4th byte transfer and lasts 1 cycle. Back-to-back words are legal (no wr_en merging).
- RAM words written before a checksum or format failure remain written. Only the count register commit is gated by the checksum.
- Address arithmetic is 9 bits: {mode[1:0], phase[6:0]}. The phase never exceeds 126, so no wrap.
- hold is sampled each cycle.
  - hold asserted mid-frame pauses acceptance; state and partial word are kept, and no timeout applies.
  - A pending wr_en is not suppressed by hold.
- A SYNC value appearing inside a frame is treated as data (no resync).
- cnt_out always reflects the committed registers. The update is visible the cycle after COMMIT.
- Reset mid-frame: returns to IDLE. Partial words are discarded and count registers revert to defaults.
- error stays 1 until the next accepted SYNC byte.

Test Plan:
- After reset with cnt_sel=0,1,2,3 -> cnt_out=98,22,52,0; in_ready=1; busy=0.
- Frame A5,80,01,11,22,33,44,CSUM=0x2B -> one wr_en at wr_addr=0x100, wr_data=0x44332211; done pulse; cnt_sel=2 gives 1.
- Mode 1, N=2, words 0x00000001 and 0xFFFFFFFF, in_valid held high continuously -> wr_en at addresses 0x080 and 0x081 on consecutive word boundaries; cnt[1]=2.
- Same frame with CSUM off by 1 -> error=1, no done, cnt[1] unchanged at 22; both RAM writes still issued; next A5 clears error.
- COUNT=0x00, then separately COUNT=0x80 -> error=1, state returns to IDLE, no wr_en.
- hold=1 for 5 cycles after the 2nd data byte -> in_ready=0, no transfer; the word completes correctly after hold drops. Also assert reset mid-DATA -> IDLE, counts revert to defaults.
